// File: rtl/cbfp1_block_scaler.sv
// Block floating-point front stage: ping-pong buffers each block and replays it with its common sign-bit count.
// Latency: sample 0 of a block leaves 2 clocks after its last sample is accepted; optional clamp via CBFP1_CLAMP_EN.
// Backpressure: none; the reader drains a bank in BLOCK_LEN clocks, never slower than the writer can refill.
module cbfp1_block_scaler #(
   parameter int INPUT_WIDTH = 25,
   parameter int SHIFT_WIDTH = 5,
   parameter int BLOCK_LEN   = 16,
   parameter int SHIFT_MAX   = 13
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic signed [INPUT_WIDTH-1:0] in_re,
   input  logic signed [INPUT_WIDTH-1:0] in_im,
   output logic                          out_valid,
   output logic signed [INPUT_WIDTH-1:0] out_re,
   output logic signed [INPUT_WIDTH-1:0] out_im,
   output logic [SHIFT_WIDTH-1:0]        out_shift,
   output logic                          out_first,
   output logic                          out_last
);

   localparam int CW = $clog2(BLOCK_LEN);
   localparam logic [SHIFT_WIDTH-1:0] MIN_INIT = SHIFT_WIDTH'(INPUT_WIDTH-1);
   localparam logic [CW-1:0]          CNT_LAST = CW'(BLOCK_LEN-1);
`ifdef CBFP1_CLAMP_EN
   localparam int CAP = SHIFT_MAX;
`else
   // A cap at INPUT_WIDTH-1 never bites, so the raw block minimum passes through.
   localparam int CAP = INPUT_WIDTH - 1 + 0 * SHIFT_MAX;
`endif
   localparam logic [SHIFT_WIDTH-1:0] SHIFT_CAP = SHIFT_WIDTH'(CAP);

   typedef enum logic {IDLE, RUN} state_t;

   logic signed [INPUT_WIDTH-1:0] mem_re [2*BLOCK_LEN];
   logic signed [INPUT_WIDTH-1:0] mem_im [2*BLOCK_LEN];

   logic                   wr_bank_q;
   logic [CW-1:0]          wr_cnt_q;
   logic [SHIFT_WIDTH-1:0] min_q, min_d;
   logic [SHIFT_WIDTH-1:0] shift_q [2];
   logic [1:0]             full_q, full_d;
   state_t                 state_q;
   logic                   rd_bank_q;
   logic [CW-1:0]          rd_cnt_q;
   logic [SHIFT_WIDTH-1:0] lsb_re, lsb_im, shift_raw, shift_d;
   logic                   wr_last, rd_done;

   function automatic logic [SHIFT_WIDTH-1:0] lsb_cnt(input logic signed [INPUT_WIDTH-1:0] x);
      logic [SHIFT_WIDTH-1:0] n;
      logic                   done;
      n    = '0;
      done = 1'b0;
      for (int i = INPUT_WIDTH-2; i >= 0; i--) begin
         if (!done && (x[i] == x[INPUT_WIDTH-1])) n = n + SHIFT_WIDTH'(1);
         else                                     done = 1'b1;
      end
      return n;
   endfunction

   assign lsb_re  = lsb_cnt(in_re);
   assign lsb_im  = lsb_cnt(in_im);
   assign wr_last = in_valid && (wr_cnt_q == CNT_LAST);
   assign rd_done = (state_q == RUN) && (rd_cnt_q == CNT_LAST);

   always_comb begin
      min_d = min_q;
      if (lsb_re < min_d) min_d = lsb_re;
      if (lsb_im < min_d) min_d = lsb_im;
   end

   // Clear and set always target different banks, so applying both is safe.
   always_comb begin
      full_d = full_q;
      if (rd_done) full_d[rd_bank_q] = 1'b0;
      if (wr_last) full_d[wr_bank_q] = 1'b1;
   end

   always_comb begin
      shift_raw = shift_q[rd_bank_q];
      shift_d   = (shift_raw > SHIFT_CAP) ? SHIFT_CAP : shift_raw;
   end

   always_ff @(posedge clk) begin
      if (in_valid) begin
         mem_re[{wr_bank_q, wr_cnt_q}] <= in_re;
         mem_im[{wr_bank_q, wr_cnt_q}] <= in_im;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank_q  <= 1'b0;
         wr_cnt_q   <= '0;
         min_q      <= MIN_INIT;
         shift_q[0] <= '0;
         shift_q[1] <= '0;
         full_q     <= '0;
      end else begin
         full_q <= full_d;
         if (in_valid) begin
            if (wr_last) begin
               shift_q[wr_bank_q] <= min_d;
               wr_bank_q          <= ~wr_bank_q;
               wr_cnt_q           <= '0;
               min_q              <= MIN_INIT;
            end else begin
               wr_cnt_q <= wr_cnt_q + CW'(1);
               min_q    <= min_d;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rd_bank_q <= 1'b0;
         rd_cnt_q  <= '0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_shift <= '0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (full_q[rd_bank_q]) begin
                  state_q  <= RUN;
                  rd_cnt_q <= '0;
               end
            end
            RUN: begin
               out_valid <= 1'b1;
               out_re    <= mem_re[{rd_bank_q, rd_cnt_q}];
               out_im    <= mem_im[{rd_bank_q, rd_cnt_q}];
               out_shift <= shift_d;
               out_first <= (rd_cnt_q == '0);
               out_last  <= (rd_cnt_q == CNT_LAST);
               if (rd_cnt_q == CNT_LAST) begin
                  rd_bank_q <= ~rd_bank_q;
                  rd_cnt_q  <= '0;
                  // Chain straight into the other bank when it is already waiting.
                  if (!full_q[~rd_bank_q]) state_q <= IDLE;
               end else begin
                  rd_cnt_q <= rd_cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cbfp1_block_scaler.sv
// Bench for cbfp1_block_scaler: directed blocks plus random blocks against a queue-based block model.
module tb_cbfp1_block_scaler;

   localparam int W  = 25;
   localparam int SW = 5;
   localparam int BL = 16;
`ifdef CBFP1_CLAMP_EN
   localparam int CAP = 13;
`else
   localparam int CAP = 99;
`endif

   typedef struct {
      int re;
      int im;
      int sh;
      int first;
      int last;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic signed [W-1:0]  in_re = '0;
   logic signed [W-1:0]  in_im = '0;
   logic                 out_valid;
   logic signed [W-1:0]  out_re;
   logic signed [W-1:0]  out_im;
   logic [SW-1:0]        out_shift;
   logic                 out_first;
   logic                 out_last;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   int   first_cyc_q[$];
   int   shift_hist[$];
   int   blk_re[$];
   int   blk_im[$];

   cbfp1_block_scaler #(
      .INPUT_WIDTH(W), .SHIFT_WIDTH(SW), .BLOCK_LEN(BL), .SHIFT_MAX(13)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
      .out_valid(out_valid), .out_re(out_re), .out_im(out_im), .out_shift(out_shift),
      .out_first(out_first), .out_last(out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Redundant sign bits = (W-1) minus the magnitude bit length of x (or ~x when negative).
   function automatic int lsb_model(input int x);
      int y, n;
      y = (x < 0) ? ~x : x;
      n = 0;
      while (y != 0) begin
         y = y >> 1;
         n++;
      end
      return W - 1 - n;
   endfunction

   function automatic int lit(input int v);
      return (v < CAP) ? v : CAP;
   endfunction

   function automatic void model_push(input int re, input int im, input int now);
      int   m;
      exp_t e;
      blk_re.push_back(re);
      blk_im.push_back(im);
      if (blk_re.size() == BL) begin
         m = W - 1;
         for (int i = 0; i < BL; i++) begin
            if (lsb_model(blk_re[i]) < m) m = lsb_model(blk_re[i]);
            if (lsb_model(blk_im[i]) < m) m = lsb_model(blk_im[i]);
         end
         for (int i = 0; i < BL; i++) begin
            e.re = blk_re[i]; e.im = blk_im[i]; e.sh = lit(m);
            e.first = (i == 0) ? 1 : 0;
            e.last  = (i == BL-1) ? 1 : 0;
            exp_q.push_back(e);
         end
         first_cyc_q.push_back(now + 3);
         blk_re.delete();
         blk_im.delete();
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int re, input int im);
      in_valid = 1'b1;
      in_re    = W'(re);
      in_im    = W'(im);
      model_push(re, im, cyc);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      chk("drain_timeout_left", exp_q.size(), 0);
      repeat (3) tick();
   endtask

   task automatic chk_shift(input string name, input int exp);
      if (shift_hist.size() == 0) chk({name, "_missing_block"}, 0, 1);
      else                        chk(name, shift_hist.pop_front(), exp);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_out_re"},    int'(out_re),    0);
      chk({tag, "_out_im"},    int'(out_im),    0);
      chk({tag, "_out_shift"}, int'(out_shift), 0);
      chk({tag, "_out_first"}, int'(out_first), 0);
      chk({tag, "_out_last"},  int'(out_last),  0);
   endtask

   // Output monitor: every valid cycle is checked against the model, idle cycles for hold and no gaps.
   int  prev_re = 0, prev_im = 0, prev_sh = 0;
   bit  mid_block = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         mid_block = 1'b0;
      end else if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output_valid", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("out_re",    int'(out_re),    e.re);
            chk("out_im",    int'(out_im),    e.im);
            chk("out_shift", int'(out_shift), e.sh);
            chk("out_first", int'(out_first), e.first);
            chk("out_last",  int'(out_last),  e.last);
         end
         if (out_first) begin
            shift_hist.push_back(int'(out_shift));
            if (first_cyc_q.size() != 0) chk("first_latency_cycle", cyc, first_cyc_q.pop_front());
         end
         mid_block = !out_last;
      end else begin
         chk("gap_inside_block",  int'(mid_block), 0);
         chk("idle_out_first",    int'(out_first), 0);
         chk("idle_out_last",     int'(out_last),  0);
         chk("idle_hold_re",      int'(out_re),    prev_re);
         chk("idle_hold_im",      int'(out_im),    prev_im);
         chk("idle_hold_shift",   int'(out_shift), prev_sh);
         mid_block = 1'b0;
      end
      prev_re = int'(out_re);
      prev_im = int'(out_im);
      prev_sh = int'(out_shift);
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic signed [W-1:0] t;
      int r, i2;

      // Model pins
      chk("pin_lsb_zero",    lsb_model(0), 24);
      chk("pin_lsb_neg1",    lsb_model(-1), 24);
      chk("pin_lsb_one",     lsb_model(1), 23);
      chk("pin_lsb_maxpos",  lsb_model(16777215), 0);
      chk("pin_lsb_maxneg",  lsb_model(-16777216), 0);
      chk("pin_lsb_pow18",   lsb_model(1 << 18), 5);

      repeat (3) @(posedge clk);
      #2;
      chk_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // 1: re=im=1
      for (int i = 0; i < BL; i++) send(1, 1);
      drain();
      chk_shift("t1_shift", lit(23));

      // 2: single full-scale positive sample
      for (int i = 0; i < BL; i++) send((i == 5) ? 16777215 : 0, 0);
      drain();
      chk_shift("t2_shift", 0);

      // 3: two back-to-back blocks, minimum 20 then 5
      for (int i = 0; i < BL; i++) send(8, 0);
      for (int i = 0; i < BL; i++) send((i == 9) ? (1 << 18) : -5, -5);
      drain();
      chk_shift("t3_shift_a", lit(20));
      chk_shift("t3_shift_b", lit(5));

      // 4: every-other-cycle input, all zero
      for (int i = 0; i < BL; i++) begin
         send(0, 0);
         tick();
      end
      drain();
      chk_shift("t4_shift", lit(24));

      // 5: reset mid-block discards the partial block
      for (int i = 0; i < 9; i++) send(3, -7);
      rst = 1'b1;
      blk_re.delete();
      blk_im.delete();
      #1;
      chk_reset_outputs("midreset");
      tick();
      rst = 1'b0;
      tick();
      for (int i = 0; i < BL; i++) send(-1, -1);
      drain();
      chk_shift("t5_shift", lit(24));
      chk("t5_no_extra_blocks", shift_hist.size(), 0);

      // 6: random blocks with random gaps
      for (int b = 0; b < 200; b++) begin
         for (int i = 0; i < BL; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            t  = W'($urandom);
            t  = t >>> $urandom_range(0, W-1);
            r  = int'(t);
            t  = W'($urandom);
            t  = t >>> $urandom_range(0, W-1);
            i2 = int'(t);
            send(r, i2);
         end
      end
      drain();
      chk("t6_blocks_seen", shift_hist.size(), 200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
